// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants and FSM encoding for the 8-way round-robin arbiter
package rr_arbiter8_pkg;
    localparam int NREQ = 8;
    localparam int ID_W = 3;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter8_prio_enc.sv
// prio_enc8_lsb: 8-to-3 priority encoder selecting the lowest set bit
module prio_enc8_lsb
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0] in,
    output logic [ID_W-1:0] idx,
    output logic            vld
);
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (in[i]) idx = ID_W'(i);
        vld = |in;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with hold limit and one-cycle handoff gap
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);
    state_t            state, state_n;
    logic [NREQ-1:0]   gnt_n;
    logic [ID_W-1:0]   id_n, last, last_n, m_idx, r_idx, pick;
    logic              vld_n, to_n, m_vld, r_vld;
    logic [CNT_W-1:0]  hold_cnt, cnt_n;
    logic [NREQ-1:0]   mask;

    // Only requesters strictly above the previous owner; empty when last=7, so search wraps to 0.
    assign mask = 8'hFE << last;
    assign pick = m_vld ? m_idx : r_idx;

    prio_enc8_lsb u_masked (.in(req & mask), .idx(m_idx), .vld(m_vld));
    prio_enc8_lsb u_full   (.in(req),        .idx(r_idx), .vld(r_vld));

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        id_n    = gnt_id;
        vld_n   = gnt_vld;
        to_n    = 1'b0;
        cnt_n   = hold_cnt;
        last_n  = last;
        if (state == ST_IDLE) begin
            if (en && r_vld) begin
                state_n = ST_GRANT;
                gnt_n   = 8'd1 << pick;
                id_n    = pick;
                vld_n   = 1'b1;
                cnt_n   = '0;
            end
        end else if (!req[gnt_id] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            // Release wins over the hold limit, so timeout only fires while the owner still requests.
            state_n = ST_IDLE;
            gnt_n   = '0;
            vld_n   = 1'b0;
            last_n  = gnt_id;
            to_n    = req[gnt_id];
        end else begin
            cnt_n = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last     <= 3'd7;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            gnt_vld  <= vld_n;
            timeout  <= to_n;
            hold_cnt <= cnt_n;
            last     <= last_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: random and directed stimulus against a grant-tracking reference model
module tb_rr_arbiter8;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [7:0] req = '0;
    logic [1:0][7:0] gnt_w;
    logic [1:0][2:0] id_w;
    logic [1:0] vld_w, to_w;
    int own[2], held[2], lst[2], mid[2];
    bit mto[2];
    int checks = 0, errors = 0, run = 0, ph;
    bit armed = 0, pv = 0, hit;
    int log_q[$];

    rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_vld(vld_w[0]), .timeout(to_w[0]));
    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_vld(vld_w[1]), .timeout(to_w[1]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // held counts granted cycles already seen; owner = -1 when nobody holds the resource
    task automatic step(input int k, input int mh);
        if (rst) begin
            own[k] = -1; held[k] = 0; lst[k] = 7; mid[k] = 0; mto[k] = 0;
        end else if (own[k] < 0) begin
            int p = -1;
            mto[k] = 0;
            if (en && req != 0) begin
                for (int i = lst[k] + 1; i < 8; i++) if (p < 0 && req[i]) p = i;
                for (int i = 0; i < 8; i++) if (p < 0 && req[i]) p = i;
                own[k] = p; mid[k] = p; held[k] = 1;
            end
        end else if (!req[own[k]]) begin
            lst[k] = own[k]; own[k] = -1; mto[k] = 0;
        end else if (held[k] == mh) begin
            lst[k] = own[k]; own[k] = -1; mto[k] = 1;
        end else begin
            held[k]++; mto[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        step(0, 16);
        step(1, 4);
    end

    always @(negedge clk) if (armed) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt%0d", k), gnt_w[k], own[k] < 0 ? 32'd0 : 32'd1 << own[k]);
            chk($sformatf("id%0d", k), id_w[k], mid[k]);
            chk($sformatf("vld%0d", k), vld_w[k], own[k] >= 0);
            chk($sformatf("to%0d", k), to_w[k], mto[k]);
        end
        if (vld_w[0] && !pv) log_q.push_back(id_w[0]);
        pv = vld_w[0];
        if (gnt_w[0] != 0) run++;
        else begin
            if (to_w[0]) chk("tolen", run, 16);
            run = 0;
        end
    end

    task automatic drain();
        req = '0;
        repeat (3) @(negedge clk);
        log_q.delete();
    endtask

    initial begin
        req = 8'hFF; en = 1'b1; rst = 1'b1;
        @(posedge clk);
        armed = 1;
        repeat (3) @(negedge clk);
        log_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("rstrel", gnt_w[0], 8'h01);
        repeat (40) begin
            req = (own[0] >= 0 && held[0] == 2) ? ~(8'd1 << own[0]) : 8'hFF;
            @(negedge clk);
        end
        for (int i = 0; i < 9; i++) chk("rot", log_q.size() > i ? log_q[i] : -1, i % 8);
        drain();
        req = 8'h20;
        repeat (40) @(negedge clk);
        chk("regrants", log_q.size(), 3);
        drain();
        req = 8'h08; ph = 0;
        repeat (60) begin
            @(negedge clk);
            if (ph == 0 && own[0] == 3 && held[0] == 4) begin req = 8'h48; ph = 1; end
            else if (ph == 1 && own[0] == 6 && held[0] == 3) begin req = 8'h08; ph = 2; end
        end
        chk("fair0", log_q.size() > 0 ? log_q[0] : -1, 3);
        chk("fair1", log_q.size() > 1 ? log_q[1] : -1, 6);
        chk("fair2", log_q.size() > 2 ? log_q[2] : -1, 3);
        drain();
        en = 1'b0; req = 8'h10;
        repeat (10) @(negedge clk);
        chk("engate", log_q.size(), 0);
        en = 1'b1;
        @(negedge clk);
        chk("en1", gnt_w[0], 8'h10);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("enhold", gnt_w[0], 8'h10);
        req = '0;
        @(negedge clk);
        chk("enrel", gnt_w[0], 8'h00);
        en = 1'b1;
        drain();
        req = 8'h04;
        repeat (3) @(negedge clk);
        rst = 1'b1; req = 8'h0D;
        @(negedge clk);
        chk("rstmid", gnt_w[0], 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rstlast", gnt_w[0], 8'h01);
        drain();
        req = 8'h02; hit = 0;
        repeat (10) begin
            @(negedge clk);
            if (!hit && own[1] == 1 && held[1] == 4) begin
                req = '0; hit = 1;
                @(negedge clk);
                chk("tie_to", to_w[1], 1'b0);
                chk("tie_vld", vld_w[1], 1'b0);
            end
        end
        chk("tie_hit", hit, 1'b1);
        repeat (600) begin
            if ($urandom % 8 == 0) req = 8'($urandom);
            en = ($urandom % 4) != 0;
            rst = ($urandom % 80) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Picks one requester, holds a registered grant while that requester keeps its request, and forces release after a hold limit.
- Uses a masked 8-to-3 priority search to rotate priority fairly.
- Sits between the lab's request sources and a single shared datapath. The grant id drives that datapath's select mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant (legal range 1..256).
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: arbitration enable. When low, no new grant is issued; an existing grant continues.
- req, input, 8: request vector; bit i is requester i.
- gnt, output, 8: one-hot grant, registered.
- gnt_id, output, 3: index of the granted requester; valid only when gnt_vld=1.
- gnt_vld, output, 1: a grant is active; equals OR of gnt.
- timeout, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst=1 at a clock edge), state after the edge:
  - state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, timeout=0, hold_cnt=0.
  - last=7, so requester 0 has top priority first.
  - Reset mid-grant drops the grant on that edge; there is no completion cycle.
- States: IDLE, GRANT.
- Priority search (combinational, from req and last):
  - mask = bits strictly above last.
  - If (req & mask) != 0, pick the lowest-index set bit of (req & mask).
  - Else, if req != 0, pick the lowest-index set bit of req.
  - Else, no candidate.
- IDLE:
  - If en=1 and a candidate exists: next edge gnt=onehot(pick), gnt_id=pick, gnt_vld=1, hold_cnt=0, state=GRANT.
  - Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE with outputs at 0.
- GRANT, each edge:
  - Release: if req[gnt_id]=0, then gnt=0, gnt_vld=0, last=gnt_id, state=IDLE.
  - Timeout: else if hold_cnt == MAX_HOLD-1, then gnt=0, gnt_vld=0, timeout=1 for one cycle, last=gnt_id, state=IDLE.
  - Otherwise hold_cnt increments; gnt and gnt_id are unchanged.
  - Requests on other lines never preempt the owner.
  - en is ignored in GRANT.
- Turnaround: every grant is followed by exactly one IDLE cycle with gnt=0, even if other requests are pending. This gives a handoff gap for the shared resource.
- A grant therefore lasts at most MAX_HOLD cycles.
- MAX_HOLD=1: every grant lasts one cycle and is followed by a timeout pulse if req[gnt_id] is still high.
- Wrap-around: after last=7 the mask is empty and the search starts at requester 0.
- Simultaneous release and timeout on the same edge: the release takes precedence and timeout stays 0.
- A timed-out requester that keeps req high is re-granted only after all other pending requesters are served.
- gnt is always one-hot or zero. gnt_id holds its last value while gnt_vld=0. Registered outputs never depend combinationally on inputs.
- Known-value rule: X or Z on req or en is not supported and needs no defined response.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1), the NREQ=8 constant, and the ID_W=3 constant.
- One sub-module, prio_enc8_lsb: an 8-to-3 lowest-index priority encoder with a valid output.
  - Instantiated twice: once on req&mask, once on req.
  - The two results are selected by the masked-valid flag.

Test Plan:
- Reset state: rst=1 with req=8'hFF -> gnt=0, gnt_vld=0, timeout=0 each cycle. Release rst with en=1 -> gnt=8'h01, gnt_id=0 one cycle later.
- Rotation: req=8'hFF held constant, MAX_HOLD=16, each owner drops req for exactly one cycle after 2 granted cycles. Expect:
  - gnt_id sequence 0,1,2,...,7,0 wrapping around.
  - One gnt=0 cycle between grants.
  - No timeout pulses.
- Timeout: only req[5]=1, held for 40 cycles, MAX_HOLD=16. Expect:
  - gnt=8'h20 for exactly 16 cycles, then timeout=1 with gnt=0 for one cycle, then re-grant of 5.
  - Pattern repeats.
- Fairness after timeout: req[3] held and granted. At grant cycle 4 raise req[6]. Expect:
  - Timeout on 3 after 16 cycles.
  - Next grant goes to 6, not 3.
  - After 6 releases, 3 is granted again.
- Enable gating: en=0 with req=8'h10 -> no grant for 10 cycles. Set en=1 -> gnt=8'h10 next cycle. Drop en while granted -> grant persists until req[4]=0.
- Mid-grant reset and release/timeout tie: assert rst during a grant of 2 -> gnt=0 the next cycle, and last=7 so requester 0 wins. With MAX_HOLD=4, drop req on the 4th grant cycle -> timeout stays 0.
